// File: rtl/alu_reg_sequencer.sv
// alu_reg_sequencer: 32-entry register file and IDLE/READ/EXEC/WB sequencer
// that feeds registered operands to an external combinational ALU.
module alu_reg_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_ld,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_zf,
    input  logic              alu_of,
    output logic              done,
    output logic              flag_zf,
    output logic              flag_of,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t state, state_nx;
    logic [DATA_W-1:0] regs [0:(1<<ADDR_W)-1];
    logic              ld_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic [DATA_W-1:0] imm_q, res_q;
    logic              zf_q, of_q;

    assign cmd_ready = state == IDLE;
    assign done      = state == WB;
    // Register 0 is never written, so it reads as zero without a mux
    assign dbg_data  = regs[dbg_addr];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cmd_valid ? (cmd_ld ? WB : READ) : IDLE;
            READ:    state_nx = EXEC;
            EXEC:    state_nx = WB;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1 << ADDR_W); i++) regs[i] <= '0;
            ld_q    <= 1'b0;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            zf_q    <= 1'b0;
            of_q    <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            flag_zf <= 1'b0;
            flag_of <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                ld_q  <= cmd_ld;
                op_q  <= cmd_op;
                rs1_q <= cmd_rs1;
                rs2_q <= cmd_rs2;
                rd_q  <= cmd_rd;
                imm_q <= cmd_imm;
            end
            if (state == READ) begin
                alu_a  <= regs[rs1_q];
                alu_b  <= regs[rs2_q];
                alu_op <= op_q;
            end
            if (state == EXEC) begin
                res_q <= alu_f;
                zf_q  <= alu_zf;
                of_q  <= alu_of;
            end
            if (state == WB) begin
                if (rd_q != '0) regs[rd_q] <= ld_q ? imm_q : res_q;
                if (!ld_q) begin
                    flag_zf <= zf_q;
                    flag_of <= of_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_reg_sequencer.sv
// tb_alu_reg_sequencer: streams directed and random commands through the
// sequencer with a behavioural ALU and a register-file reference model.
module tb_alu_reg_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_ld = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [4:0]  cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
    logic [31:0] cmd_imm = '0;
    logic [31:0] alu_a, alu_b, alu_f;
    logic [2:0]  alu_op;
    logic        alu_zf, alu_of;
    logic        done, flag_zf, flag_of;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ld;
        logic [2:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
    } cmd_t;

    typedef struct {
        cmd_t        c;
        int          acc;
        logic [31:0] val;
        logic        zf, of;
    } pend_t;

    cmd_t        q[$];
    pend_t       pend[$];
    logic [31:0] mreg [32];
    logic        mzf, mof;

    alu_reg_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ld(cmd_ld), .cmd_op(cmd_op),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of),
        .done(done), .flag_zf(flag_zf), .flag_of(flag_of),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU
    always_comb begin
        alu_f  = '0;
        alu_of = 1'b0;
        case (alu_op)
            3'd0: alu_f = alu_a & alu_b;
            3'd1: alu_f = alu_a | alu_b;
            3'd2: alu_f = alu_a ^ alu_b;
            3'd3: alu_f = ~(alu_a | alu_b);
            3'd4: begin
                alu_f  = alu_a + alu_b;
                alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'd5: begin
                alu_f  = alu_a - alu_b;
                alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'd6: alu_f = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_f = alu_b << alu_a[4:0];
        endcase
        alu_zf = alu_f == '0;
    end

    // Reference result as {of, f} using wide signed arithmetic
    function automatic logic [32:0] ref_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s  = 0;
        logic [31:0] f = '0;
        logic of = 1'b0;
        case (op)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~(a | b);
            3'd4: begin s = sa + sb; f = s[31:0]; of = s > 64'sd2147483647 || s < -64'sd2147483648; end
            3'd5: begin s = sa - sb; f = s[31:0]; of = s > 64'sd2147483647 || s < -64'sd2147483648; end
            3'd6: f = (sa < sb) ? 32'd1 : 32'd0;
            default: f = b << a[4:0];
        endcase
        return {of, f};
    endfunction

    function automatic cmd_t mk(logic ld, logic [2:0] op, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic [31:0] imm);
        cmd_t c;
        c.ld = ld; c.op = op; c.rs1 = rs1; c.rs2 = rs2; c.rd = rd; c.imm = imm;
        return c;
    endfunction

    task automatic drive(cmd_t c);
        cmd_ld = c.ld; cmd_op = c.op; cmd_rs1 = c.rs1; cmd_rs2 = c.rs2;
        cmd_rd = c.rd; cmd_imm = c.imm;
    endtask

    task automatic model_reset();
        foreach (mreg[i]) mreg[i] = '0;
        mzf = 1'b0;
        mof = 1'b0;
        pend.delete();
    endtask

    task automatic check_reg(logic [4:0] a, logic [31:0] exp, string name);
        @(negedge clk);
        dbg_addr = a;
        #1;
        checks++;
        if (dbg_data !== exp) begin
            errors++;
            $display("FAIL %s: r%0d got %h expected %h", name, a, dbg_data, exp);
        end
    endtask

    task automatic check_all(string name);
        for (int a = 0; a < 32; a++) check_reg(5'(a), mreg[a], name);
    endtask

    task automatic check_flags(logic zf, logic of, string name);
        @(negedge clk);
        checks++;
        if (flag_zf !== zf || flag_of !== of) begin
            errors++;
            $display("FAIL %s: zf/of got %b%b expected %b%b", name, flag_zf, flag_of, zf, of);
        end
    endtask

    // Presents q with cmd_valid held high; checks accept spacing, done latency,
    // no-bypass visibility during WB, and spurious or missing done pulses.
    task automatic stream();
        int n = q.size();
        int acc = 0, dn = 0, cyc = 0, last = 0, lat;
        logic rdy;
        logic [32:0] r;
        pend_t p;
        @(negedge clk);
        drive(q[0]);
        cmd_valid = 1'b1;
        while (dn < n && cyc < 8 * n + 20) begin
            if (done) begin
                checks++;
                if (pend.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done: done=1 expected 0 at cycle %0d", cyc);
                end else begin
                    p = pend.pop_front();
                    lat = cyc - p.acc + 1;
                    if (lat != (p.c.ld ? 1 : 3)) begin
                        errors++;
                        $display("FAIL done_latency: got %0d expected %0d", lat, p.c.ld ? 1 : 3);
                    end
                    dbg_addr = p.c.rd;
                    #1;
                    checks++;
                    if (dbg_data !== mreg[p.c.rd]) begin
                        errors++;
                        $display("FAIL wb_old_value: r%0d got %h expected %h", p.c.rd, dbg_data, mreg[p.c.rd]);
                    end
                    if (p.c.rd != 0) mreg[p.c.rd] = p.val;
                    if (!p.c.ld) begin mzf = p.zf; mof = p.of; end
                    dn++;
                end
            end
            rdy = cmd_ready;
            @(posedge clk);
            cyc++;
            if (rdy && acc < n) begin
                if (acc > 0) begin
                    checks++;
                    if (cyc - last != (q[acc-1].ld ? 2 : 4)) begin
                        errors++;
                        $display("FAIL accept_spacing: got %0d expected %0d", cyc - last, q[acc-1].ld ? 2 : 4);
                    end
                end
                p.c = q[acc];
                p.acc = cyc;
                r = ref_alu(q[acc].op, mreg[q[acc].rs1], mreg[q[acc].rs2]);
                p.val = q[acc].ld ? q[acc].imm : r[31:0];
                p.zf = r[31:0] == '0;
                p.of = r[32];
                pend.push_back(p);
                last = cyc;
                acc++;
                #1;
                if (acc < n) drive(q[acc]);
                else cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (dn < n) begin
            errors++;
            $display("FAIL stream_timeout: completed %0d expected %0d", dn, n);
        end
        q.delete();
        pend.delete();
        check_flags(mzf, mof, "stream_flags");
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || alu_a !== '0 || alu_b !== '0 || alu_op !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b done=%b a=%h b=%h op=%0d expected 1 0 0 0 0",
                     cmd_ready, done, alu_a, alu_b, alu_op);
        end
        rst_n = 1'b1;
        check_flags(1'b0, 1'b0, "reset_flags");
        check_all("reset_regs");
    endtask

    task automatic test_add();
        q.push_back(mk(1, 0, 0, 0, 1, 32'h3));
        q.push_back(mk(1, 0, 0, 0, 2, 32'h607));
        q.push_back(mk(0, 4, 1, 2, 3, 0));
        stream();
        check_reg(3, 32'h0000060A, "add_r3");
        check_flags(1'b0, 1'b0, "add_flags");
    endtask

    task automatic test_overflow();
        q.push_back(mk(1, 0, 0, 0, 1, 32'h7FFFFFFF));
        q.push_back(mk(0, 4, 1, 1, 4, 0));
        stream();
        check_reg(4, 32'hFFFFFFFE, "ovf_r4");
        check_flags(1'b0, 1'b1, "ovf_flags");
        q.push_back(mk(0, 5, 4, 4, 5, 0));
        stream();
        check_reg(5, 32'h0, "sub_r5");
        check_flags(1'b1, 1'b0, "sub_flags");
    endtask

    task automatic test_sll_r0();
        q.push_back(mk(1, 0, 0, 0, 1, 32'h4));
        q.push_back(mk(1, 0, 0, 0, 2, 32'h1));
        q.push_back(mk(0, 7, 1, 2, 6, 0));
        q.push_back(mk(1, 0, 0, 0, 0, 32'hDEADBEEF));
        stream();
        check_reg(6, 32'h00000010, "sll_r6");
        check_reg(0, 32'h0, "r0_zero");
    endtask

    task automatic test_queued();
        q.push_back(mk(0, 2, 1, 2, 8, 0));
        q.push_back(mk(0, 1, 8, 1, 8, 0));
        q.push_back(mk(0, 6, 8, 8, 8, 0));
        stream();
        check_all("queued_regs");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) q.push_back(mk(1, 0, 0, 0, 5'(9 + i), $urandom));
        stream();
        check_all("b2b_regs");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            q.push_back(mk(($urandom_range(0, 9) < 4), 3'($urandom), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom));
        stream();
        check_all("random_regs");
    endtask

    task automatic test_reset_mid();
        q.push_back(mk(1, 0, 0, 0, 1, 32'h11));
        q.push_back(mk(1, 0, 0, 0, 2, 32'h22));
        stream();
        @(negedge clk);
        drive(mk(0, 4, 1, 2, 7, 0));
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (alu_a !== 32'h11 || alu_b !== 32'h22 || alu_op !== 3'd4) begin
            errors++;
            $display("FAIL exec_operands: a=%h b=%h op=%0d expected 11 22 4", alu_a, alu_b, alu_op);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || alu_a !== '0 || alu_b !== '0 || alu_op !== '0
            || flag_zf !== 1'b0 || flag_of !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: ready=%b done=%b a=%h b=%h op=%0d zf=%b of=%b",
                     cmd_ready, done, alu_a, alu_b, alu_op, flag_zf, flag_of);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL midreset_done: got %b expected 0", done);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_idle: done=%b ready=%b expected 0 1", done, cmd_ready);
            end
        end
        check_reg(7, 32'h0, "midreset_r7");
        check_all("midreset_regs");
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_sll_r0();
        test_queued();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
